// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART byte-stream ALU: opcodes, FSM encoding
// and status-byte bit positions.
package uart_alu_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_XOR = 8'h02;
    localparam logic [7:0] OP_MAX = 8'h03;

    // State encoding doubles as the LED code on state_o.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    localparam int ST_BORROW = 0;
    localparam int ST_BADOP  = 1;

endpackage

// File: rtl/uart_alu_accum.sv
// Accumulator datapath: loaded with the first operand of a frame, then
// folded with each following operand according to the opcode.
module uart_alu_accum
    import uart_alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         hwclk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [7:0]   opcode,
    input  logic [W-1:0] operand,
    output logic [W-1:0] acc,
    output logic         borrow,
    output logic         bad_op
);

    // Load starts a fresh frame (flags cleared); step folds one more operand in.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            borrow <= 1'b0;
            bad_op <= 1'b0;
        end else if (load) begin
            borrow <= 1'b0;
            bad_op <= (opcode > OP_MAX);
            acc    <= (opcode > OP_MAX) ? '0 : operand;
        end else if (step) begin
            case (opcode)
                OP_ADD: acc <= acc + operand;
                OP_SUB: begin
                    acc <= acc - operand;
                    if (operand > acc) begin
                        borrow <= 1'b1;
                    end
                end
                OP_XOR: acc <= acc ^ operand;
                OP_MAX: begin
                    if (operand > acc) begin
                        acc <= operand;
                    end
                end
                default: acc <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_alu_engine.sv
// Byte-stream ALU: collects opcode + operands from the UART receiver,
// computes the result and streams echo/result/status to the transmitter.
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int OPERAND_BYTES  = 1,
    parameter int NUM_OPERANDS   = 2,
    parameter int ECHO           = 1,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [1:0] state_o,
    output logic       frame_err,
    output logic       rx_overrun
);

    localparam int RB       = OPERAND_BYTES + 1;
    localparam int W        = 8 * RB;
    localparam int TOTAL    = NUM_OPERANDS * OPERAND_BYTES;
    localparam int ECHO_LEN = (ECHO != 0) ? TOTAL : 0;
    localparam int TX_LEN   = ECHO_LEN + RB + 1;
    localparam int SW       = $clog2(TOTAL);
    localparam int OW       = $clog2(NUM_OPERANDS);
    localparam int TXW      = $clog2(TX_LEN);
    localparam int TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SW-1:0]  LAST_BYTE = SW'(TOTAL - 1);
    localparam logic [OW-1:0]  LAST_OP   = OW'(NUM_OPERANDS - 1);
    localparam logic [TXW-1:0] ECHO_END  = TXW'(ECHO_LEN);
    localparam logic [TXW-1:0] TX_LAST   = TXW'(TX_LEN - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     state;
    logic [7:0]     opcode;
    logic [SW-1:0]  byte_cnt;
    logic [OW-1:0]  op_idx;
    logic [TXW-1:0] tx_idx;
    logic [TW-1:0]  tmo_cnt;
    logic [7:0]     store [TOTAL];
    logic [W-1:0]   cur_operand;
    logic [W-1:0]   acc;
    logic           borrow;
    logic           bad_op;
    logic [7:0]     status_byte;

    // Main FSM: request collection with inter-byte timeout, operand sweep, response send.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            opcode     <= '0;
            byte_cnt   <= '0;
            op_idx     <= '0;
            tx_idx     <= '0;
            tmo_cnt    <= '0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
            for (int i = 0; i < TOTAL; i++) begin
                store[i] <= '0;
            end
        end else begin
            frame_err  <= 1'b0;
            rx_overrun <= rx_valid && ((state == ST_CALC) || (state == ST_SEND));
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode   <= rx_byte;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        state    <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        store[byte_cnt] <= rx_byte;
                        tmo_cnt         <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            op_idx <= '0;
                            state  <= ST_CALC;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
                        frame_err <= 1'b1;
                        byte_cnt  <= '0;
                        tmo_cnt   <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CALC: begin
                    if (op_idx == LAST_OP) begin
                        tx_idx <= '0;
                        state  <= ST_SEND;
                    end else begin
                        op_idx <= op_idx + 1'b1;
                    end
                end
                default: begin
                    if (tx_ready) begin
                        if (tx_idx == TX_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Assemble the current operand big-endian from the store, zero-extended to W bits.
    always_comb begin
        cur_operand = '0;
        for (int j = 0; j < OPERAND_BYTES; j++) begin
            cur_operand = {cur_operand[W-9:0], store[SW'(int'(op_idx) * OPERAND_BYTES + j)]};
        end
    end

    uart_alu_accum #(
        .W(W)
    ) u_accum (
        .hwclk   (hwclk),
        .reset   (reset),
        .load    ((state == ST_CALC) && (op_idx == '0)),
        .step    ((state == ST_CALC) && (op_idx != '0)),
        .opcode  (opcode),
        .operand (cur_operand),
        .acc     (acc),
        .borrow  (borrow),
        .bad_op  (bad_op)
    );

    // Status flags packed into the trailing response byte.
    always_comb begin
        status_byte            = '0;
        status_byte[ST_BORROW] = borrow;
        status_byte[ST_BADOP]  = bad_op;
    end

    // Transmit mux: echo bytes, then result MSB first, then status.
    always_comb begin
        tx_byte = '0;
        if (state == ST_SEND) begin
            tx_byte = status_byte;
            for (int b = 0; b < RB; b++) begin
                if (tx_idx == TXW'(ECHO_LEN + b)) begin
                    tx_byte = acc[8*(RB-1-b) +: 8];
                end
            end
            if ((ECHO != 0) && (tx_idx < ECHO_END)) begin
                tx_byte = store[SW'(tx_idx)];
            end
        end
    end

    assign tx_valid = (state == ST_SEND);
    assign busy     = (state != ST_IDLE);
    assign state_o  = state;

endmodule

// File: tb/tb_uart_alu_engine.sv
// Directed bench for uart_alu_engine: one task per scenario, each with its
// own hand-computed expected response bytes.
module tb_uart_alu_engine;

    localparam int TB_TIMEOUT = 300;

    logic       hwclk = 1'b0;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [1:0] state_o;
    logic       frame_err;
    logic       rx_overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got [8];
    int got_n;
    int hold_err;
    int bubble_err;
    int ovr_cnt;
    bit cap_timeout;

    uart_alu_engine #(
        .OPERAND_BYTES  (1),
        .NUM_OPERANDS   (2),
        .ECHO           (1),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .hwclk      (hwclk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .state_o    (state_o),
        .frame_err  (frame_err),
        .rx_overrun (rx_overrun)
    );

    // Free-running clock, 10 time units per period.
    always #5 hwclk = ~hwclk;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one byte on the rx strobe for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge hwclk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    // Record n response bytes; optional 5-cycle stall before each transfer and
    // optional rx byte injected during transfer number 'inject'.
    task automatic capture_response(input int n, input bit stall, input int inject);
        int budget;
        logic [7:0] hold;
        got_n = 0; hold_err = 0; bubble_err = 0; ovr_cnt = 0; cap_timeout = 0;
        for (int i = 0; i < n; i++) begin
            budget = 0;
            while (!tx_valid && budget < 50) begin
                @(negedge hwclk);
                if (rx_overrun) ovr_cnt++;
                budget++;
            end
            if (!tx_valid) begin
                cap_timeout = 1;
                break;
            end
            if (i > 0 && budget != 0) bubble_err++;
            if (stall) begin
                hold = tx_byte;
                tx_ready = 1'b0;
                repeat (5) begin
                    @(negedge hwclk);
                    if (rx_overrun) ovr_cnt++;
                    if (!tx_valid || tx_byte !== hold) hold_err++;
                end
                tx_ready = 1'b1;
            end
            if (i == inject) begin
                rx_byte  = 8'h55;
                rx_valid = 1'b1;
            end
            got[i] = tx_byte;
            got_n++;
            @(negedge hwclk);
            rx_valid = 1'b0;
            if (rx_overrun) ovr_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
        repeat (3) @(negedge hwclk);
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_vec++; if (tx_byte !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
        n_vec++; if ({frame_err, rx_overrun} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_pulses: got %b expected 00", {frame_err, rx_overrun}); end
        reset = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic test_add();
        logic [7:0] exp [5] = '{8'hC8, 8'h64, 8'h01, 8'h2C, 8'h00};
        send_frame(8'h00, 8'hC8, 8'h64);
        n_vec++; if (state_o !== 2'd2 || tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_calc1: got state %0d tx_valid %b expected 2/0", state_o, tx_valid); end
        @(negedge hwclk);
        n_vec++; if (state_o !== 2'd2 || tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_calc2: got state %0d tx_valid %b expected 2/0", state_o, tx_valid); end
        @(negedge hwclk);
        n_vec++; if (state_o !== 2'd3 || tx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL add_send_start: got state %0d tx_valid %b expected 3/1", state_o, tx_valid); end
        capture_response(5, 1'b0, -1);
        n_vec++; if (got_n != 5) begin n_err++; $display("[TB] FAIL add_count: got %0d expected 5", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_vec++; if (got[i] !== exp[i]) begin n_err++; $display("[TB] FAIL add_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        n_vec++; if (bubble_err != 0) begin n_err++; $display("[TB] FAIL add_bubble: got %0d expected 0", bubble_err); end
        n_vec++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_done: got busy %b tx_valid %b expected 0/0", busy, tx_valid); end
    endtask

    // Send a frame and compare the five response bytes plus the return to IDLE.
    task automatic test_simple(input string name, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r_hi, input logic [7:0] r_lo, input logic [7:0] st);
        logic [7:0] exp [5];
        exp = '{a, b, r_hi, r_lo, st};
        send_frame(op, a, b);
        capture_response(5, 1'b0, -1);
        n_vec++; if (got_n != 5) begin n_err++; $display("[TB] FAIL %s_count: got %0d expected 5", name, got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_vec++; if (got[i] !== exp[i]) begin n_err++; $display("[TB] FAIL %s_byte%0d: got %h expected %h", name, i, got[i], exp[i]); end
        end
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("[TB] FAIL %s_idle: got %0d expected 0", name, state_o); end
    endtask

    task automatic test_timeout();
        int k = 0;
        bit saw_tx = 0;
        send_byte(8'h00);
        send_byte(8'h11);
        while (!frame_err && k < TB_TIMEOUT + 50) begin
            @(negedge hwclk);
            k++;
            if (tx_valid) saw_tx = 1;
        end
        n_vec++; if (k != TB_TIMEOUT) begin n_err++; $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", k, TB_TIMEOUT); end
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("[TB] FAIL timeout_state: got %0d expected 0", state_o); end
        @(negedge hwclk);
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", frame_err); end
        n_vec++; if (saw_tx) begin n_err++; $display("[TB] FAIL timeout_no_tx: got tx activity expected none"); end
        test_simple("recover", 8'h00, 8'h01, 8'h02, 8'h00, 8'h03, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5] = '{8'hA5, 8'h3C, 8'h00, 8'h99, 8'h00};
        send_frame(8'h02, 8'hA5, 8'h3C);
        capture_response(5, 1'b1, -1);
        n_vec++; if (got_n != 5) begin n_err++; $display("[TB] FAIL stall_count: got %0d expected 5", got_n); end
        for (int i = 0; i < got_n; i++) begin
            n_vec++; if (got[i] !== exp[i]) begin n_err++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        n_vec++; if (hold_err != 0) begin n_err++; $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", hold_err); end
        n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stall_done: got %b expected 0", tx_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [5] = '{8'h10, 8'h03, 8'h00, 8'h0D, 8'h00};
        send_frame(8'h01, 8'h10, 8'h03);
        capture_response(5, 1'b0, 1);
        n_vec++; if (ovr_cnt != 1) begin n_err++; $display("[TB] FAIL overrun_pulses: got %0d expected 1", ovr_cnt); end
        for (int i = 0; i < got_n; i++) begin
            n_vec++; if (got[i] !== exp[i]) begin n_err++; $display("[TB] FAIL overrun_byte%0d: got %h expected %h", i, got[i], exp[i]); end
        end
        n_vec++; if (state_o !== 2'd0) begin n_err++; $display("[TB] FAIL overrun_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_reset_mid_send();
        send_frame(8'h00, 8'h20, 8'h30);
        capture_response(2, 1'b0, -1);
        n_vec++; if (got[0] !== 8'h20 || got[1] !== 8'h30) begin n_err++; $display("[TB] FAIL midreset_pre: got %h %h expected 20 30", got[0], got[1]); end
        n_vec++; if (tx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_sending: got %b expected 1", tx_valid); end
        reset = 1'b1;
        #1;
        n_vec++; if (tx_valid !== 1'b0 || state_o !== 2'd0) begin n_err++; $display("[TB] FAIL midreset_drop: got tx_valid %b state %0d expected 0/0", tx_valid, state_o); end
        @(negedge hwclk);
        reset = 1'b0;
        @(negedge hwclk);
        test_simple("postreset", 8'h03, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h00);
    endtask

    initial begin
        test_reset();
        test_add();
        test_simple("sub", 8'h01, 8'h05, 8'h07, 8'hFF, 8'hFE, 8'h01);
        test_simple("badop", 8'h09, 8'h10, 8'h20, 8'h00, 8'h00, 8'h02);
        test_simple("max", 8'h03, 8'h33, 8'h44, 8'h00, 8'h44, 8'h00);
        test_timeout();
        test_back_to_back();
        test_overrun();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_alu_engine.md
# uart_alu_engine

Byte-stream arithmetic engine between the UART receiver/transmitter byte strobes and the board, all on `hwclk`. It collects a framed request of one opcode byte followed by `NUM_OPERANDS` big-endian operands of `OPERAND_BYTES` bytes each, and computes add, sub, xor or max across the operands. It then streams back an optional echo of the operands, the result and a status byte. It is the parametrised successor of the fixed two-byte adder and adds an opcode, an inter-byte timeout, transmit back-pressure and overrun reporting.

## Interface
- `OPERAND_BYTES`, 1, bytes per operand (1..4); result width `RB = OPERAND_BYTES+1` bytes.
- `NUM_OPERANDS`, 2, operands per frame (2..256).
- `ECHO`, 1, 1 = echo received operand bytes before the result.
- `TIMEOUT_CYCLES`, 120000, maximum idle `hwclk` cycles between request bytes (10 ms at 12 MHz); 0 disables the timeout.
- `hwclk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_byte`  in  8  received byte, valid while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `tx_byte`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid & tx_ready` are high at a rising edge.
- `busy`  out  1  high in any state other than IDLE.
- `state_o`  out  2  encoded state for the LEDs: IDLE=0, RECV=1, CALC=2, SEND=3.
- `frame_err`  out  1  one-cycle pulse when a frame is dropped on timeout.
- `rx_overrun`  out  1  one-cycle pulse when a byte arrives in CALC or SEND; that byte is discarded.

## Operation
- Reset values: all outputs 0; state IDLE; counters, operand store and accumulator cleared.
- **IDLE:** `rx_valid` latches the opcode and moves to RECV. The byte counter and the timeout counter are cleared.
- **RECV:** each `rx_valid` stores `rx_byte` into the operand store. Operand k, byte j (0 = MSB) goes to index `k*OPERAND_BYTES+j`. The accepted byte after which the count reaches `NUM_OPERANDS*OPERAND_BYTES` moves to CALC.
- **Timeout:** the counter increments each cycle in RECV and clears on every accepted byte. When it reaches `TIMEOUT_CYCLES`, the FSM pulses `frame_err`, returns to IDLE and discards the partial frame.
- **CALC:** one operand per cycle for `NUM_OPERANDS` cycles. Operands are zero-extended to `8*RB` bits. The accumulator is loaded with operand 0, then combined with operands 1..N-1:
  - 0x00 add: modulo 2^(8·RB); cannot overflow within the parameter ranges.
  - 0x01 sub: `acc - op`, modulo 2^(8·RB). `borrow` is set sticky if any step has `op > acc`.
  - 0x02 xor.
  - 0x03 max: unsigned maximum.
  - Any other opcode: result 0, `bad_op` set.
- **Status byte:** bit0 = `borrow`, bit1 = `bad_op`, other bits 0.
- **SEND:** transmit order is:
  - if `ECHO`: the stored operand bytes, in receive order;
  - then the result, MSB first, `RB` bytes;
  - then the status byte.
  - After the last accepted transfer the FSM returns to IDLE.
- `rx_valid` in CALC or SEND pulses `rx_overrun` in the next cycle. It does not affect the response.

## Timing
- State changes take effect at the rising edge that samples the triggering strobe.
- If the last request byte is accepted at edge t, CALC spans edges t+1 … t+N. `tx_valid` is high from after edge t+N and holds through SEND.
- While `tx_valid & !tx_ready`, `tx_byte` holds stable. After a transfer, the next byte appears the following cycle; `tx_valid` stays high with no bubble.
- `tx_valid` falls in the cycle after the status-byte transfer. A new opcode can be accepted in that same cycle.
- Asserting `reset` at any point (including mid-SEND) forces `tx_valid=0` and IDLE immediately; there is no partial resume.
- `rx_valid` coinciding with the timeout expiry edge: the byte is accepted and the timeout is cancelled.

## Structure
- Package `uart_alu_pkg`:
  - opcode constants (`OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_MAX`);
  - state encoding (0..3, matching `state_o`);
  - status bit indices (`ST_BORROW=0`, `ST_BADOP=1`).
- Sub-module `uart_alu_accum` holds the accumulator datapath: load/step inputs, opcode, operand, and outputs `acc`, `borrow`, `bad_op`.
- The top level contains the FSM, byte and timeout counters, the operand store and the tx byte mux.

## Test plan
All scenarios use default parameters and hold `tx_ready=1` unless stated.
- **Add:** rx 00 C8 64 -> tx C8 64 01 2C 00; `busy` falls after the last byte.
- **Sub with borrow:** rx 01 05 07 -> tx 05 07 FF FE 01.
- **Bad opcode:** rx 09 10 20 -> tx 10 20 00 00 02. **Max:** rx 03 33 44 -> tx 33 44 00 44 00.
- **Timeout, then recovery:** rx 00 11, then no bytes for 120000 cycles -> one `frame_err` pulse, no tx, state IDLE. Next, rx 00 01 02 -> tx 01 02 00 03 00.
- **Back-pressure and overrun:** `tx_ready` low for 5 cycles before each transfer -> every byte is held stable and none are lost or duplicated. rx 55 during SEND -> one `rx_overrun` pulse and an unchanged response.
- **Reset mid-SEND:** assert `reset` after 2 bytes have been sent -> `tx_valid` drops immediately and `state_o`=0. A following frame is processed correctly.
